// File: rtl/me_search_controller.sv
`default_nettype none
// ============================================================================
//  Module      : me_search_controller
//  Description : Full-search block-matching sequencer. Walks 16 candidate
//                rows: clears the 16-PE SAD array, streams the 16x16
//                reference block and two search-window columns into the PEs,
//                then scans the 16 PE results and keeps the best candidate.
//                All outputs are registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module me_search_controller #(
    parameter int SAD_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [SAD_W-1:0] sad_in,
    output logic [7:0]       AddressR,
    output logic [9:0]       AddressS1,
    output logic [9:0]       AddressS2,
    output logic             pe_clear,
    output logic             pe_valid,
    output logic [3:0]       pe_sel,
    output logic             busy,
    output logic             done,
    output logic [3:0]       motionx,
    output logic [3:0]       motiony,
    output logic [SAD_W-1:0] best_sad
);

    // Search window is 31 pixels wide; port 2 reads 15 columns to the right.
    localparam logic [9:0] c_WIN_W   = 10'd31;
    localparam logic [9:0] c_S2_OFFS = 10'd15;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_ACCUM   = 3'd2,
        S_COMPARE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t           r_state;
    logic [3:0]       r_y;          // candidate row
    logic [7:0]       r_c;          // pixel counter, {j, i}
    logic [3:0]       r_k;          // compare counter / PE index
    logic [7:0]       r_addr_r;
    logic [9:0]       r_addr_s1;
    logic [9:0]       r_addr_s2;
    logic             r_pe_clear;
    logic             r_pe_valid;
    logic [3:0]       r_pe_sel;
    logic             r_busy;
    logic             r_done;
    logic [3:0]       r_motionx;
    logic [3:0]       r_motiony;
    logic [SAD_W-1:0] r_best_sad;

    // Addresses are registered, so they are computed for the pixel index
    // that the next ACCUM cycle will present (c=0 when leaving CLEAR).
    logic [7:0] w_c_nxt;
    logic [9:0] w_row_nxt;
    logic [9:0] w_s1_nxt;
    logic [9:0] w_s2_nxt;
    logic       w_better;

    // Next-pixel address arithmetic and strict-less comparison.
    always_comb begin
        w_c_nxt   = (r_state == S_CLEAR) ? 8'd0 : (r_c + 8'd1);
        w_row_nxt = {6'd0, r_y} + {6'd0, w_c_nxt[7:4]};
        w_s1_nxt  = (w_row_nxt * c_WIN_W) + {6'd0, w_c_nxt[3:0]};
        w_s2_nxt  = w_s1_nxt + c_S2_OFFS;
        w_better  = (sad_in < r_best_sad);
    end

    // Sequencing FSM with its registered outputs and the best-candidate tracker.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_y        <= 4'd0;
            r_c        <= 8'd0;
            r_k        <= 4'd0;
            r_addr_r   <= 8'd0;
            r_addr_s1  <= 10'd0;
            r_addr_s2  <= 10'd0;
            r_pe_clear <= 1'b0;
            r_pe_valid <= 1'b0;
            r_pe_sel   <= 4'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_motionx  <= 4'd0;
            r_motiony  <= 4'd0;
            r_best_sad <= {SAD_W{1'b1}};
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        // A new search discards the previous result so an
                        // all-saturated window reports candidate (0,0).
                        r_y        <= 4'd0;
                        r_best_sad <= {SAD_W{1'b1}};
                        r_motionx  <= 4'd0;
                        r_motiony  <= 4'd0;
                        r_pe_clear <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= S_CLEAR;
                    end
                end

                S_CLEAR: begin
                    r_pe_clear <= 1'b0;
                    r_c        <= 8'd0;
                    r_pe_valid <= 1'b1;
                    r_addr_r   <= w_c_nxt;
                    r_addr_s1  <= w_s1_nxt;
                    r_addr_s2  <= w_s2_nxt;
                    r_state    <= S_ACCUM;
                end

                S_ACCUM: begin
                    if (r_c == 8'd255) begin
                        r_k        <= 4'd0;
                        r_pe_valid <= 1'b0;
                        r_addr_r   <= 8'd0;
                        r_addr_s1  <= 10'd0;
                        r_addr_s2  <= 10'd0;
                        r_pe_sel   <= 4'd0;
                        r_state    <= S_COMPARE;
                    end else begin
                        r_c       <= w_c_nxt;
                        r_addr_r  <= w_c_nxt;
                        r_addr_s1 <= w_s1_nxt;
                        r_addr_s2 <= w_s2_nxt;
                    end
                end

                S_COMPARE: begin
                    // Strict less-than: ties keep the earlier candidate.
                    if (w_better) begin
                        r_best_sad <= sad_in;
                        r_motionx  <= r_k;
                        r_motiony  <= r_y;
                    end
                    if (r_k == 4'd15) begin
                        r_pe_sel <= 4'd0;
                        if (r_y == 4'd15) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_y        <= r_y + 4'd1;
                            r_pe_clear <= 1'b1;
                            r_state    <= S_CLEAR;
                        end
                    end else begin
                        r_k      <= r_k + 4'd1;
                        r_pe_sel <= r_k + 4'd1;
                    end
                end

                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state    <= S_IDLE;
                    r_pe_clear <= 1'b0;
                    r_pe_valid <= 1'b0;
                    r_busy     <= 1'b0;
                    r_done     <= 1'b0;
                end
            endcase
        end
    end

    assign AddressR  = r_addr_r;
    assign AddressS1 = r_addr_s1;
    assign AddressS2 = r_addr_s2;
    assign pe_clear  = r_pe_clear;
    assign pe_valid  = r_pe_valid;
    assign pe_sel    = r_pe_sel;
    assign busy      = r_busy;
    assign done      = r_done;
    assign motionx   = r_motionx;
    assign motiony   = r_motiony;
    assign best_sad  = r_best_sad;

endmodule
`default_nettype wire
